// File: rtl/operand_fetch.sv
// operand_fetch
//   Operand fetch stage: a 32 x 32-bit register file with a pending-write
//   scoreboard. A decoded instruction is accepted when it has no RAW/WAW
//   hazard and the output slot is free; the operand bundle (opCode, dataA,
//   dataB, destReg) is registered and presented with a valid/ready handshake.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   inValid / inReady     decoded-instruction handshake
//   opCodeIn, rsIn, rtIn, rdIn, immIn, useImm   decoded instruction fields
//   outValid / outReady   operand-bundle handshake
//   opCode, dataA, dataB, destReg               registered operand bundle
//   wbEnable, wbReg, wbData                     writeback port
//
// Configuration
//   OPERAND_FETCH_BYPASS_EN  when defined, a source register whose only
//   hazard is a writeback in the same cycle is forwarded from wbData instead
//   of stalling.
module operand_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  output logic        inReady,
  input  logic [4:0]  opCodeIn,
  input  logic [4:0]  rsIn,
  input  logic [4:0]  rtIn,
  input  logic [4:0]  rdIn,
  input  logic [15:0] immIn,
  input  logic        useImm,
  output logic        outValid,
  input  logic        outReady,
  output logic [4:0]  opCode,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [4:0]  destReg,
  input  logic        wbEnable,
  input  logic [4:0]  wbReg,
  input  logic [31:0] wbData
);

  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;

  logic [31:0] regs_q [32];
  logic [31:0] pending_q, pending_d;
  logic        valid_q, valid_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  dest_q, dest_d;

  logic        wb_wr;
  logic        byp_a, byp_b;
  logic        haz_a, haz_b, haz_d;
  logic        accept;
  logic [31:0] src_a, src_b, imm_ext;

  // Writes to register 0 are dropped everywhere, so it stays hardwired zero.
  assign wb_wr = wbEnable && (wbReg != 5'd0);

  // Register file: reset must clear every entry, so it is built from flops.
  assign regs_q[0] = 32'd0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          regs_q[gi] <= 32'd0;
        end else if (wb_wr && (wbReg == 5'(gi))) begin
          regs_q[gi] <= wbData;
        end
      end
    end
  endgenerate

`ifdef OPERAND_FETCH_BYPASS_EN
  assign byp_a = wb_wr && (wbReg == rsIn);
  assign byp_b = wb_wr && (wbReg == rtIn);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  assign src_a   = byp_a ? wbData : regs_q[rsIn];
  assign src_b   = byp_b ? wbData : regs_q[rtIn];
  assign imm_ext = ((opCodeIn == OP_ANDI) || (opCodeIn == OP_ORI)) ?
                   {16'd0, immIn} : {{16{immIn[15]}}, immIn};

  // A forwarded source is no longer a hazard; WAW always stalls.
  assign haz_a = pending_q[rsIn] && !byp_a;
  assign haz_b = !useImm && pending_q[rtIn] && !byp_b;
  assign haz_d = (rdIn != 5'd0) && pending_q[rdIn];

  // inReady depends only on state, instruction fields and writeback, never on inValid.
  assign inReady = (!valid_q || outReady) && !(haz_a || haz_b || haz_d);
  assign accept  = inValid && inReady;

  always_comb begin
    pending_d = pending_q;
    if (wb_wr) begin
      pending_d[wbReg] = 1'b0;
    end
    // Applied after the clear so a same-cycle set of the same bit wins.
    if (accept && (rdIn != 5'd0)) begin
      pending_d[rdIn] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dest_d  = dest_q;
    valid_d = valid_q && !outReady;
    if (accept) begin
      op_d    = opCodeIn;
      a_d     = src_a;
      b_d     = useImm ? imm_ext : src_b;
      dest_d  = rdIn;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= 32'd0;
      valid_q   <= 1'b0;
      op_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      dest_q    <= 5'd0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
    end
  end

  assign outValid = valid_q;
  assign opCode   = op_q;
  assign dataA    = a_q;
  assign dataB    = b_q;
  assign destReg  = dest_q;

endmodule
